// File: rtl/bit_serializer.sv
// bit_serializer: accepts parallel words over a valid/ready handshake and shifts
// them out one bit per clock on dout/dout_valid. frame_start/frame_end mark
// word boundaries for the downstream detector. An optional idle gap follows
// each frame. All outputs except in_ready and busy come straight from registers.
module bit_serializer #(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy,
    output logic [7:0]        frames_sent
);
    localparam int              CNT_W        = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_BIT = CNT_W'(DATA_W - 2);
    localparam bit              HAS_GAP      = (GAP_CYCLES > 0);
    localparam int              GAP_LAST_I   = HAS_GAP ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]      GAP_LAST     = 4'(GAP_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // r_bit_cnt is the index (in transmit order) of the bit currently on dout.
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_next;
    logic [3:0]          r_gap_cnt;
    logic [3:0]          w_gap_cnt_next;
    logic                r_dout;
    logic                w_dout_next;
    logic                r_dout_valid;
    logic                w_dout_valid_next;
    logic                r_frame_start;
    logic                w_frame_start_next;
    logic                r_frame_end;
    logic                w_frame_end_next;
    logic [7:0]          r_frames_sent;
    logic [7:0]          w_frames_sent_next;

    logic                w_last_bit;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_load_bit;
    logic [DATA_W-1:0]   w_load_rest;
    logic                w_step_bit;
    logic [DATA_W-1:0]   w_step_rest;

    // The final bit of a frame is on dout this cycle.
    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);
    assign w_accept   = in_valid && w_in_ready;

    // Bit ordering: the shift register always presents the next bit at one end.
    assign w_load_bit  = MSB_FIRST ? in_data[DATA_W-1] : in_data[0];
    assign w_load_rest = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign w_step_bit  = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
    assign w_step_rest = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: frame end leads to GAP, a chained frame, or IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (HAS_GAP) begin
                        w_state_next = ST_GAP;
                    end else if (w_accept) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: handshake and the next values of the registered outputs.
    always_comb begin
        w_in_ready         = (r_state == ST_IDLE) || (w_last_bit && !HAS_GAP);
        w_shift_next       = r_shift;
        w_bit_cnt_next     = r_bit_cnt;
        w_gap_cnt_next     = r_gap_cnt;
        w_dout_next        = 1'b0;
        w_dout_valid_next  = 1'b0;
        w_frame_start_next = 1'b0;
        w_frame_end_next   = 1'b0;
        w_frames_sent_next = r_frames_sent;

        if (w_last_bit) begin
            w_frames_sent_next = r_frames_sent + 8'd1;
            w_bit_cnt_next     = '0;
            w_gap_cnt_next     = '0;
        end

        if (r_state == ST_GAP) begin
            w_gap_cnt_next = r_gap_cnt + 4'd1;
        end

        if (w_accept) begin
            // First bit of the new word goes out in the cycle after the accept.
            w_shift_next       = w_load_rest;
            w_bit_cnt_next     = '0;
            w_dout_next        = w_load_bit;
            w_dout_valid_next  = 1'b1;
            w_frame_start_next = 1'b1;
        end else if ((r_state == ST_SHIFT) && !w_last_bit) begin
            w_shift_next       = w_step_rest;
            w_bit_cnt_next     = r_bit_cnt + 1'b1;
            w_dout_next        = w_step_bit;
            w_dout_valid_next  = 1'b1;
            w_frame_end_next   = (r_bit_cnt == PRE_LAST_BIT);
        end
    end

    // Datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_dout        <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frames_sent <= 8'd0;
        end else begin
            r_shift       <= w_shift_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_gap_cnt     <= w_gap_cnt_next;
            r_dout        <= w_dout_next;
            r_dout_valid  <= w_dout_valid_next;
            r_frame_start <= w_frame_start_next;
            r_frame_end   <= w_frame_end_next;
            r_frames_sent <= w_frames_sent_next;
        end
    end

    assign in_ready    = w_in_ready;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = (r_state != ST_IDLE);
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer. Three instances: A (MSB first, no gap),
// B (LSB first, no gap), C (MSB first, 3-cycle gap). Stimulus pushes the
// expected {dout,frame_start,frame_end} triples into per-instance queues;
// a negedge monitor pops and compares whenever dout_valid is high.
module tb_bit_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] in_valid;
    logic [7:0] in_data [3];
    wire  [2:0] in_ready;
    wire  [2:0] dout;
    wire  [2:0] dout_valid;
    wire  [2:0] fs;
    wire  [2:0] fe;
    wire  [2:0] busy;
    wire  [23:0] frames_bus;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .reset(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
        .frame_start(fs[0]), .frame_end(fe[0]), .busy(busy[0]),
        .frames_sent(frames_bus[7:0])
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
        .frame_start(fs[1]), .frame_end(fe[1]), .busy(busy[1]),
        .frames_sent(frames_bus[15:8])
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u_dut_c (
        .clk(clk), .reset(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
        .frame_start(fs[2]), .frame_end(fe[2]), .busy(busy[2]),
        .frames_sent(frames_bus[23:16])
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];

    bit         mon_en = 1'b0;
    int         popped   [3] = '{0, 0, 0};
    int         run_len  [3] = '{0, 0, 0};
    int         last_run [3] = '{0, 0, 0};
    int         adj_cnt  [3] = '{0, 0, 0};
    logic [2:0] prev_fe = 3'b000;
    int         idle_busy_c = 0;
    int         idle_free_c = 0;
    int         ready_in_gap_c = 0;
    int         last_gap_busy_c = -1;
    int         last_gap_free_c = -1;

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] frames_of(input int k);
        return frames_bus[k*8 +: 8];
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0d required=%0d", name, k, got, exp);
        end
    endtask

    // Expected transmit order: instance B is LSB first, the others MSB first.
    task automatic push_word(input int k, input logic [7:0] d, input int nbits);
        logic [2:0] e;
        for (int i = 0; i < nbits; i++) begin
            e[2] = (k == 1) ? d[i] : d[7-i];
            e[1] = (i == 0);
            e[0] = (i == 7);
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Offer a word and wait (bounded) for the accept edge. With hold=1 in_valid
    // stays high so the caller can chain the next word immediately.
    task automatic send(input int k, input logic [7:0] d, input bit hold, input int nbits);
        int waited;
        push_word(k, d, nbits);
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", k, 32'(in_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        $display("sent dut%0d data=%h", k, d);
        if (!hold) begin
            in_valid[k] = 1'b0;
            in_data[k]  = 8'($urandom);
        end
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((qsize(k) != 0 || busy[k] !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", k, 32'(qsize(k)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare plus contiguity and gap statistics.
    always @(negedge clk) begin : mon
        logic [2:0] got;
        logic [2:0] exp_v;
        bit         have;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                got = {dout[k], fs[k], fe[k]};
                if (dout_valid[k] === 1'b1) begin
                    have  = 1'b0;
                    exp_v = 3'b000;
                    case (k)
                        0: if (q0.size() > 0) begin exp_v = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin exp_v = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin exp_v = q2.pop_front(); have = 1'b1; end
                    endcase
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL unexpected_bit dut%0d got={dout,start,end}=%b required=none", k, got);
                    end else begin
                        popped[k]++;
                        if (got !== exp_v) begin
                            errors++;
                            $display("FAIL bit dut%0d got={dout,start,end}=%b required=%b", k, got, exp_v);
                        end
                    end
                    checks++;
                    if (busy[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_in_frame dut%0d got=%b required=1", k, busy[k]);
                    end
                    if (prev_fe[k] && fs[k]) adj_cnt[k]++;
                    run_len[k]++;
                end else begin
                    checks++;
                    if (got !== 3'b000) begin
                        errors++;
                        $display("FAIL idle_outputs dut%0d got={dout,start,end}=%b required=000", k, got);
                    end
                    if (run_len[k] > 0) last_run[k] = run_len[k];
                    run_len[k] = 0;
                end
                prev_fe[k] = dout_valid[k] & fe[k];
            end
            // Gap statistics for instance C.
            if (dout_valid[2] !== 1'b1) begin
                if (busy[2] === 1'b1) begin
                    idle_busy_c++;
                    if (in_ready[2] !== 1'b0) ready_in_gap_c++;
                end else begin
                    idle_free_c++;
                end
            end else if (fs[2] === 1'b1) begin
                last_gap_busy_c = idle_busy_c;
                last_gap_free_c = idle_free_c;
                idle_busy_c = 0;
                idle_free_c = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int adj_before;
        int popped_before;
        rst      = 3'b111;
        in_valid = 3'b000;
        for (int k = 0; k < 3; k++) in_data[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst    = 3'b000;
        mon_en = 1'b1;

        // Reset state of every instance.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", k, 32'(in_ready[k]), 32'd1);
            chk("reset_busy", k, 32'(busy[k]), 32'd0);
            chk("reset_dout_valid", k, 32'(dout_valid[k]), 32'd0);
            chk("reset_frames_sent", k, 32'(frames_of(k)), 32'd0);
        end
        @(posedge clk);
        #1;

        // 1: single word 1011_0010, MSB first.
        send(0, 8'b1011_0010, 1'b0, 8);
        wait_drain(0);
        chk("t1_frames_sent", 0, 32'(frames_of(0)), 32'd1);

        // 2: LSB first, 8'h01 -> 1 then seven 0s.
        send(1, 8'h01, 1'b0, 8);
        wait_drain(1);
        chk("t2_frames_sent", 1, 32'(frames_of(1)), 32'd1);

        // 3: back-to-back A5 then 3C with in_valid held high.
        adj_before = adj_cnt[0];
        send(0, 8'hA5, 1'b1, 8);
        send(0, 8'h3C, 1'b0, 8);
        wait_drain(0);
        chk("t3_contiguous_run", 0, 32'(last_run[0]), 32'd16);
        chk("t3_start_after_end", 0, 32'(adj_cnt[0] - adj_before), 32'd1);
        chk("t3_frames_sent", 0, 32'(frames_of(0)), 32'd3);

        // 4: 3-cycle gap. The gap itself is 3 busy cycles with in_ready low;
        // the following IDLE cycle is where the second word is accepted.
        send(2, 8'h5A, 1'b1, 8);
        send(2, 8'hC3, 1'b0, 8);
        wait_drain(2);
        chk("t4_gap_cycles", 2, 32'(last_gap_busy_c), 32'd3);
        chk("t4_accept_cycle", 2, 32'(last_gap_free_c), 32'd1);
        chk("t4_ready_in_gap", 2, 32'(ready_in_gap_c), 32'd0);
        chk("t4_frames_sent", 2, 32'(frames_of(2)), 32'd2);

        // 5: reset during the 4th bit of 8'hFF.
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("t5_frames_cleared", 0, 32'(frames_of(0)), 32'd0);
        send(0, 8'hFF, 1'b0, 4);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("t5_dout_valid", 0, 32'(dout_valid[0]), 32'd0);
        chk("t5_in_ready", 0, 32'(in_ready[0]), 32'd1);
        chk("t5_busy", 0, 32'(busy[0]), 32'd0);
        chk("t5_bits_emitted", 0, 32'(qsize(0)), 32'd0);
        repeat (12) @(negedge clk);
        chk("t5_frames_sent", 0, 32'(frames_of(0)), 32'd0);
        @(posedge clk);
        #1;

        // 6: 256 back-to-back frames; counter wraps to 0, every bit accounted for.
        popped_before = popped[0];
        for (int i = 0; i < 256; i++) begin
            send(0, 8'(i * 37 + 11), (i != 255), 8);
        end
        wait_drain(0);
        chk("t6_frames_wrap", 0, 32'(frames_of(0)), 32'd0);
        chk("t6_bits_seen", 0, 32'(popped[0] - popped_before), 32'd2048);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
